alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
- Issue-side counterpart of the CPU's 16-way ALU result selector.
- Accepts one instruction per handshake and decodes its 4-bit opcode into a one-hot start pulse to one of 16 functional units (demux direction).
- Waits for that unit to complete, then drives the function-select code to the result mux and flags the result valid.
- Sits between the instruction decode stage and the ALU unit bank / result mux.

Parameters:
- N, 16, operand data width.
- MULTI_MASK, 16'hC000, bit i = 1 marks unit i as multi-cycle (waits for unit_done[i]); bit i = 0 marks unit i as single-cycle.
- TIMEOUT, 255, maximum WAIT cycles before forced completion; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  dispatcher can accept.
- opcode  input  4  function index 0..15.
- dst  input  4  destination register tag.
- op_a  input  N  operand A.
- op_b  input  N  operand B.
- unit_start  output  16  one-hot start pulse to the functional units.
- unit_a  output  N  registered operand A to the units.
- unit_b  output  N  registered operand B to the units.
- unit_done  input  16  per-unit completion strobes.
- fn_sel  output  5  select code to the result mux, {1'b0, opcode}.
- res_valid  output  1  result on the mux output is valid this cycle.
- res_dst  output  4  destination tag accompanying res_valid.
- err_timeout  output  1  current result was forced by timeout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - unit_start, unit_a, unit_b, fn_sel, res_valid, res_dst, err_timeout and busy are all 0.
  - Wait counter clears.
  - instr_ready=1 as soon as rst deasserts.
  - Reset mid-operation abandons the instruction; no res_valid is produced for it.
- States: IDLE, ISSUE, WAIT, RESULT. Encoding is free.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready at an edge: register opcode into fn_sel[3:0] (fn_sel[4]=0), dst, op_a and op_b; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - unit_start = 1 << opcode; all other bits 0.
  - Counter cleared.
  - If MULTI_MASK[opcode]=0, go to RESULT. Otherwise go to WAIT.
- WAIT:
  - unit_start=0. Counter increments each cycle.
  - Only unit_done[opcode] is sampled; all other done bits are ignored.
  - unit_done[opcode]=1: go to RESULT with err=0.
  - Otherwise, counter == TIMEOUT-1: go to RESULT with err=1.
  - Done and timeout in the same cycle: done wins, err=0.
- RESULT (exactly 1 cycle):
  - res_valid=1, res_dst=latched dst, err_timeout=err. Then go to IDLE.
- Never-asserted strobes:
  - unit_done pulses in IDLE, ISSUE or RESULT are ignored and not remembered.
  - instr_ready=0 in ISSUE, WAIT and RESULT.
- Holding and clearing:
  - fn_sel, unit_a and unit_b hold their latched values until the next accept.
  - res_valid and err_timeout are 0 outside RESULT.
- Latency:
  - Accept edge at end of cycle T, unit_start high in T+1.
  - Single-cycle op: res_valid in T+2.
  - Multi-cycle op: res_valid the cycle after unit_done is sampled in WAIT.
  - Throughput: one single-cycle op per 3 cycles.

Optional Feature:
- Macro: ALU_DISPATCH_PIPE_EN.
- Defined:
  - instr_ready is also 1 in RESULT.
  - An accept in RESULT latches the new instruction and goes straight to ISSUE, skipping IDLE.
  - fn_sel and res_dst keep the old values during the RESULT cycle and update at the accept edge.
  - Single-cycle throughput becomes one op per 2 cycles.
- Undefined: instr_ready is 1 only in IDLE, as described above.

Test Plan:
- Reset: assert rst mid-WAIT with opcode 15 → all outputs 0 immediately, state IDLE, no res_valid afterwards, instr_ready=1 the cycle after rst deasserts.
- Single-cycle op: opcode=3, dst=5, op_a=16'h1234, op_b=16'h0001 accepted at T:
  - unit_start=16'h0008 in T+1, unit_a=16'h1234, unit_b=16'h0001.
  - res_valid=1, fn_sel=5'h03, res_dst=5, err_timeout=0 in T+2.
  - instr_ready=1 in T+3.
- Multi-cycle op: opcode=14, unit_done[14] pulsed 4 cycles after the ISSUE cycle, stray unit_done[2] pulses during WAIT → stray pulses ignored; res_valid and fn_sel=5'h0E in the cycle after unit_done[14].
- Timeout: opcode=15, TIMEOUT=8, no done → res_valid=1, err_timeout=1 exactly 8 WAIT cycles after ISSUE. Repeat with unit_done[15] on the final WAIT cycle → err_timeout=0.
- Back-pressure: instr_valid held high with opcode=0 then 1 → second instruction accepted only in IDLE; unit_start shows 16'h0001 then 16'h0002, never both in one cycle.
- With ALU_DISPATCH_PIPE_EN: continuous single-cycle ops 0..3 → res_valid every 2nd cycle, fn_sel sequence 0,1,2,3, no lost or duplicated results.

Source files
------------

// File: rtl/alu_dispatch.sv
// Issue-side dispatcher: decodes an opcode into a one-hot unit start, waits for completion, then flags the result.
// Optional macro ALU_DISPATCH_PIPE_EN lets a new instruction be accepted during the RESULT cycle.
module alu_dispatch #(
    parameter int          N          = 16,
    parameter logic [15:0] MULTI_MASK = 16'hC000,
    parameter int          TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [3:0]   opcode,
    input  logic [3:0]   dst,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic [15:0]  unit_start,
    output logic [N-1:0] unit_a,
    output logic [N-1:0] unit_b,
    input  logic [15:0]  unit_done,
    output logic [4:0]   fn_sel,
    output logic         res_valid,
    output logic [3:0]   res_dst,
    output logic         err_timeout,
    output logic         busy
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          sel_done;

`ifdef ALU_DISPATCH_PIPE_EN
    assign instr_ready = !rst && ((state == IDLE) || (state == RESULT));
`else
    assign instr_ready = !rst && (state == IDLE);
`endif

    assign accept   = instr_valid && instr_ready;
    assign busy     = (state != IDLE);
    // Only the done strobe of the unit that was actually started matters.
    assign sel_done = unit_done[fn_sel[3:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            unit_start  <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            fn_sel      <= '0;
            res_valid   <= 1'b0;
            res_dst     <= '0;
            err_timeout <= 1'b0;
        end else begin
            unit_start  <= '0;
            res_valid   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        fn_sel     <= {1'b0, opcode};
                        res_dst    <= dst;
                        unit_a     <= op_a;
                        unit_b     <= op_b;
                        unit_start <= 16'b1 << opcode;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (MULTI_MASK[fn_sel[3:0]]) begin
                        state <= WAIT;
                    end else begin
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (sel_done) begin
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end else if (cnt == CNT_LAST) begin
                        res_valid   <= 1'b1;
                        err_timeout <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESULT: begin
                    // accept can only be high here when the pipelined build is enabled.
                    if (accept) begin
                        fn_sel     <= {1'b0, opcode};
                        res_dst    <= dst;
                        unit_a     <= op_a;
                        unit_b     <= op_b;
                        unit_start <= 16'b1 << opcode;
                        state      <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed scenarios plus randomized transactions against a latency/outcome model.
module tb_alu_dispatch;

    localparam int          N  = 16;
    localparam int          TO = 8;
    localparam logic [15:0] MM = 16'hC000;
`ifdef ALU_DISPATCH_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [3:0]   opcode = '0;
    logic [3:0]   dst = '0;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '0;
    logic [15:0]  unit_start;
    logic [N-1:0] unit_a;
    logic [N-1:0] unit_b;
    logic [15:0]  unit_done = '0;
    logic [4:0]   fn_sel;
    logic         res_valid;
    logic [3:0]   res_dst;
    logic         err_timeout;
    logic         busy;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_dispatch #(.N(N), .MULTI_MASK(MM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .dst(dst), .op_a(op_a), .op_b(op_b),
        .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done),
        .fn_sel(fn_sel), .res_valid(res_valid), .res_dst(res_dst),
        .err_timeout(err_timeout), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({unit_start, unit_a, unit_b, fn_sel, res_valid, res_dst, err_timeout, busy, instr_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got start=%h a=%h b=%h fn=%h rv=%b dst=%h err=%b busy=%b rdy=%b want all 0",
                     unit_start, unit_a, unit_b, fn_sel, res_valid, res_dst, err_timeout, busy, instr_ready);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b busy=%b want rdy=1 busy=0", instr_ready, busy);
        end
        // Start opcode 15 and abandon it in the middle of WAIT.
        instr_valid = 1'b1; opcode = 4'd15; dst = 4'd9; op_a = 16'hBEEF; op_b = 16'h0F0F;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({unit_start, unit_a, unit_b, fn_sel, res_valid, res_dst, err_timeout, busy, instr_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_midwait: got start=%h a=%h b=%h fn=%h rv=%b dst=%h err=%b busy=%b rdy=%b want all 0",
                     unit_start, unit_a, unit_b, fn_sel, res_valid, res_dst, err_timeout, busy, instr_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_after: got rdy=%b busy=%b want rdy=1 busy=0", instr_ready, busy);
        end
        for (int c = 0; c < 12; c++) begin
            unit_done = 16'hFFFF;
            tick();
            n_cmp++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_result c%0d: got rv=%b busy=%b want 0 0", c, res_valid, busy);
            end
        end
        unit_done = '0;
    endtask

    task automatic test_single();
        instr_valid = 1'b1; opcode = 4'd3; dst = 4'd5; op_a = 16'h1234; op_b = 16'h0001;
        tick();
        instr_valid = 1'b0; opcode = 4'd7; dst = 4'd0; op_a = '0; op_b = '0;
        n_cmp++;
        if (unit_start !== 16'h0008 || unit_a !== 16'h1234 || unit_b !== 16'h0001 || instr_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: got start=%h a=%h b=%h rdy=%b busy=%b want 0008 1234 0001 0 1",
                     unit_start, unit_a, unit_b, instr_ready, busy);
        end
        tick();
        n_cmp++;
        if (res_valid !== 1'b1 || fn_sel !== 5'h03 || res_dst !== 4'd5 || err_timeout !== 1'b0 || unit_start !== 16'h0) begin
            n_fail++;
            $display("FAIL single_result: got rv=%b fn=%h dst=%0d err=%b start=%h want 1 03 5 0 0000",
                     res_valid, fn_sel, res_dst, err_timeout, unit_start);
        end
        tick();
        n_cmp++;
        if (instr_ready !== 1'b1 || res_valid !== 1'b0 || fn_sel !== 5'h03 || unit_a !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_after: got rdy=%b rv=%b fn=%h a=%h want 1 0 03 1234", instr_ready, res_valid, fn_sel, unit_a);
        end
    endtask

    // Accept one instruction from IDLE; pulse unit_done[op] d cycles after ISSUE (ISSUE is cycle 0).
    task automatic test_wait_scenario(input logic [3:0] op, input logic [3:0] dtag, input logic [N-1:0] a,
                                      input logic [N-1:0] b, input int d, input bit stray, input string name);
        int  rc;
        bit  err;
        logic [15:0] sel_bit;
        sel_bit = 16'b1 << op;
        if (!MM[op]) begin
            rc = 1; err = 1'b0;
        end else if (d >= 1 && d <= TO) begin
            rc = d + 1; err = 1'b0;
        end else begin
            rc = TO + 1; err = 1'b1;
        end
        instr_valid = 1'b1; opcode = op; dst = dtag; op_a = a; op_b = b;
        tick();
        instr_valid = 1'b0; opcode = 4'($urandom); dst = 4'($urandom); op_a = N'($urandom); op_b = N'($urandom);
        for (int k = 0; k <= rc; k++) begin
            n_cmp++;
            if (unit_start !== ((k == 0) ? sel_bit : 16'h0) || res_valid !== (k == rc) ||
                err_timeout !== ((k == rc) ? err : 1'b0) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s k%0d: got start=%h rv=%b err=%b busy=%b want start=%h rv=%b err=%b busy=1", name, k,
                         unit_start, res_valid, err_timeout, busy, (k == 0) ? sel_bit : 16'h0, k == rc, (k == rc) ? err : 1'b0);
            end
            if (k == 0) begin
                n_cmp++;
                if (unit_a !== a || unit_b !== b) begin
                    n_fail++;
                    $display("FAIL %s operands: got a=%h b=%h want a=%h b=%h", name, unit_a, unit_b, a, b);
                end
            end
            if (k == rc) begin
                n_cmp++;
                if (fn_sel !== {1'b0, op} || res_dst !== dtag) begin
                    n_fail++;
                    $display("FAIL %s result_tag: got fn=%h dst=%h want fn=%h dst=%h", name, fn_sel, res_dst, {1'b0, op}, dtag);
                end
            end
            unit_done = stray ? (16'($urandom) & ~sel_bit) : 16'h0;
            if (stray && k == 0) unit_done[op] = 1'($urandom);
            if (k == d) unit_done[op] = 1'b1;
            tick();
        end
        unit_done = '0;
        n_cmp++;
        if (instr_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: got rdy=%b rv=%b busy=%b want 1 0 0", name, instr_ready, res_valid, busy);
        end
    endtask

    task automatic test_multi();
        test_wait_scenario(4'd14, 4'd2, 16'hA5A5, 16'h5A5A, 4, 1'b0, "multi_op14");
        // Stray pulses on every other unit, including unit 2, must not complete unit 14.
        test_wait_scenario(4'd14, 4'd3, 16'h0102, 16'h0304, 4, 1'b1, "multi_op14_stray");
    endtask

    task automatic test_timeout();
        test_wait_scenario(4'd15, 4'd7, 16'h1111, 16'h2222, 0, 1'b0, "timeout_nodone");
        test_wait_scenario(4'd15, 4'd8, 16'h3333, 16'h4444, TO, 1'b0, "timeout_done_last");
        test_wait_scenario(4'd15, 4'd9, 16'h5555, 16'h6666, TO + 1, 1'b0, "timeout_done_late");
    endtask

    task automatic test_back_to_back();
        int s2;
        int starts;
        s2 = PIPE ? 3 : 4;
        starts = 0;
        instr_valid = 1'b1; opcode = 4'd0; dst = 4'd1; op_a = 16'h0A0A; op_b = 16'h0B0B;
        for (int c = 1; c <= s2 + 3; c++) begin
            tick();
            if (c == 1) begin opcode = 4'd1; dst = 4'd2; end
            if (c == s2) instr_valid = 1'b0;
            n_cmp++;
            if (unit_start !== ((c == 1) ? 16'h0001 : (c == s2) ? 16'h0002 : 16'h0000) || $countones(unit_start) > 1) begin
                n_fail++;
                $display("FAIL b2b_start c%0d: got %h want %h", c, unit_start,
                         (c == 1) ? 16'h0001 : (c == s2) ? 16'h0002 : 16'h0000);
            end
            if (unit_start != 16'h0) starts++;
            if (c == s2 + 1) begin
                n_cmp++;
                if (res_valid !== 1'b1 || fn_sel !== 5'h01 || res_dst !== 4'd2) begin
                    n_fail++;
                    $display("FAIL b2b_second_result: got rv=%b fn=%h dst=%h want 1 01 2", res_valid, fn_sel, res_dst);
                end
            end
        end
        n_cmp++;
        if (starts != 2) begin
            n_fail++;
            $display("FAIL b2b_start_count: got %0d want 2", starts);
        end
    endtask

`ifdef ALU_DISPATCH_PIPE_EN
    task automatic test_pipe();
        logic [4:0] expq[$];
        int         got;
        got = 0;
        expq = {5'h00, 5'h01, 5'h02, 5'h03};
        instr_valid = 1'b1; opcode = 4'd0; dst = 4'd0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) opcode = 4'd1;
            if (c == 3) opcode = 4'd2;
            if (c == 5) opcode = 4'd3;
            if (c == 7) instr_valid = 1'b0;
            n_cmp++;
            if (res_valid !== (c == 2 || c == 4 || c == 6 || c == 8)) begin
                n_fail++;
                $display("FAIL pipe_rv c%0d: got %b want %b", c, res_valid, (c == 2 || c == 4 || c == 6 || c == 8));
            end
            if (res_valid === 1'b1) begin
                got++;
                n_cmp++;
                if (expq.size() == 0 || fn_sel !== expq[0]) begin
                    n_fail++;
                    $display("FAIL pipe_fn c%0d: got %h want %h", c, fn_sel, (expq.size() == 0) ? 5'h1F : expq[0]);
                end
                if (expq.size() != 0) void'(expq.pop_front());
            end
        end
        n_cmp++;
        if (got != 4 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL pipe_count: got %0d results, %0d left want 4 results, 0 left", got, expq.size());
        end
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            test_wait_scenario(4'($urandom), 4'($urandom), N'($urandom), N'($urandom),
                               $urandom_range(1, TO + 2), 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_timeout();
        test_back_to_back();
        tick();
        tick();
`ifdef ALU_DISPATCH_PIPE_EN
        test_pipe();
        tick();
        tick();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
